// File: rtl/serial_link_arbiter.sv
// Round-robin, packet-granular arbiter sharing one 32-bit valid/ready serial-out link among
// NUM_CLIENTS requesters. A grant stays locked until the whole packet (header + L words) crosses.
module serial_link_arbiter #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned ID_W        = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_CLIENTS-1:0]    in_valid,
    output logic [NUM_CLIENTS-1:0]    in_ready,
    input  logic [32*NUM_CLIENTS-1:0] in_bits,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_bits,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      pkt_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HEAD = 2'd1;
    localparam logic [1:0] BODY = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    logic [31:0]      words [NUM_CLIENTS];
    logic             active;
    logic             sel_valid;
    logic             handshake;
    logic             req_found;
    logic [ID_W-1:0]  req_winner;

    for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_client
        assign words[k]    = in_bits[32*k +: 32];
        assign in_ready[k] = active && out_ready && (grant_q == ID_W'(k));
    end

    // Outputs are gated by reset_n so nothing is forwarded during the reset cycle itself.
    assign active    = reset_n && (state_q != IDLE);
    assign sel_valid = in_valid[grant_q];
    assign out_valid = active && sel_valid;
    assign out_bits  = out_valid ? words[grant_q] : 32'h0;
    assign handshake = out_valid && out_ready;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign pkt_done  = done_q;

    // First requester at or after rr_q, wrapping modulo NUM_CLIENTS.
    always_comb begin
        int unsigned     sum;
        logic [ID_W-1:0] cand;
        req_found  = 1'b0;
        req_winner = '0;
        sum        = 0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            sum = 32'(rr_q) + i;
            if (sum >= NUM_CLIENTS) begin
                sum = sum - NUM_CLIENTS;
            end
            cand = ID_W'(sum);
            if (!req_found && in_valid[cand]) begin
                req_found  = 1'b1;
                req_winner = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d = req_winner;
                    if (32'(req_winner) == NUM_CLIENTS - 1) begin
                        rr_d = '0;
                    end else begin
                        rr_d = req_winner + ID_W'(1);
                    end
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (handshake) begin
                    count_d = words[grant_q][LEN_W-1:0];
                    if (words[grant_q][LEN_W-1:0] == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                if (handshake) begin
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

endmodule
